// File: rtl/ladybird_riscv_helper_pkg.sv
// RV32I field constants, decoded-instruction types and the pure decode function
// shared by the ladybird fetch-to-execute path.
package ladybird_riscv_helper;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [3:0] {
    CLS_LOAD     = 4'd0,
    CLS_STORE    = 4'd1,
    CLS_OP_IMM   = 4'd2,
    CLS_OP       = 4'd3,
    CLS_LUI      = 4'd4,
    CLS_AUIPC    = 4'd5,
    CLS_BRANCH   = 4'd6,
    CLS_JAL      = 4'd7,
    CLS_JALR     = 4'd8,
    CLS_MISC_MEM = 4'd9,
    CLS_SYSTEM   = 4'd10,
    CLS_ILLEGAL  = 4'd11
  } inst_class_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    inst_class_t     inst_class;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [31:0]     imm;
    logic            rd_we;
    logic            illegal;
  } decoded_inst_t;

  function automatic decoded_inst_t decode_inst(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    decoded_inst_t d;
    logic [6:0]    f7;
    logic [2:0]    f3;
    logic          bad;
    logic          wr;
    f7           = inst[31:25];
    f3           = inst[14:12];
    bad          = 1'b0;
    wr           = 1'b0;
    d.pc         = pc;
    d.inst_class = CLS_ILLEGAL;
    d.rd         = inst[11:7];
    d.rs1        = inst[19:15];
    d.rs2        = inst[24:20];
    d.funct3     = f3;
    d.imm        = '0;
    case (inst[6:0])
      OPCODE_LOAD: begin
        d.inst_class = CLS_LOAD;
        d.imm        = {{20{inst[31]}}, inst[31:20]};
        wr           = 1'b1;
        bad          = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPCODE_STORE: begin
        d.inst_class = CLS_STORE;
        d.imm        = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        bad          = (f3 > 3'd2);
      end
      OPCODE_OP_IMM: begin
        d.inst_class = CLS_OP_IMM;
        wr           = 1'b1;
        // Shift amounts are unsigned; funct7 must be a valid shift qualifier.
        if (f3 == 3'd1) begin
          d.imm = {27'd0, inst[24:20]};
          bad   = (f7 != 7'h00);
        end else if (f3 == 3'd5) begin
          d.imm = {27'd0, inst[24:20]};
          bad   = (f7 != 7'h00) && (f7 != 7'h20);
        end else begin
          d.imm = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPCODE_OP: begin
        d.inst_class = CLS_OP;
        wr           = 1'b1;
        bad          = ((f7 != 7'h00) && (f7 != 7'h20)) ||
                       ((f7 == 7'h20) && (f3 != 3'd0) && (f3 != 3'd5));
      end
      OPCODE_LUI: begin
        d.inst_class = CLS_LUI;
        d.imm        = {inst[31:12], 12'd0};
        wr           = 1'b1;
      end
      OPCODE_AUIPC: begin
        d.inst_class = CLS_AUIPC;
        d.imm        = {inst[31:12], 12'd0};
        wr           = 1'b1;
      end
      OPCODE_BRANCH: begin
        d.inst_class = CLS_BRANCH;
        d.imm        = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        bad          = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPCODE_JAL: begin
        d.inst_class = CLS_JAL;
        d.imm        = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        wr           = 1'b1;
      end
      OPCODE_JALR: begin
        d.inst_class = CLS_JALR;
        d.imm        = {{20{inst[31]}}, inst[31:20]};
        wr           = 1'b1;
        bad          = (f3 != 3'd0);
      end
      OPCODE_MISC_MEM: begin
        d.inst_class = CLS_MISC_MEM;
      end
      OPCODE_SYSTEM: begin
        d.inst_class = CLS_SYSTEM;
        if (f3 == 3'd4) begin
          bad = 1'b1;
        end else if (f3 == 3'd0) begin
          bad = (inst != INST_ECALL) && (inst != INST_EBREAK) && (inst != INST_MRET);
        end else begin
          wr = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d.inst_class = CLS_ILLEGAL;
      d.imm        = '0;
      wr           = 1'b0;
    end
    d.rd_we   = wr && (inst[11:7] != 5'd0);
    d.illegal = bad;
    return d;
  endfunction

endpackage

// File: rtl/ladybird_skid_buffer.sv
// Two-entry (main + skid) valid/ready register stage; ready is a flop-only output
// and the main register reloads an idle pattern whenever it empties.
module ladybird_skid_buffer #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  T     i_idle_data,
  input  logic i_in_valid,
  output logic o_in_ready,
  input  T     i_in_data,
  output logic o_out_valid,
  input  logic i_out_ready,
  output T     o_out_data
);

  logic r_m_valid;
  logic r_s_valid;
  T     r_m_data;
  T     r_s_data;
  logic w_in_fire;
  logic w_m_open;

  assign w_in_fire = i_in_valid && !r_s_valid;
  assign w_m_open  = !r_m_valid || i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= i_idle_data;
      r_s_data  <= i_idle_data;
    end else if (i_flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= i_idle_data;
    end else if (w_m_open) begin
      // S holds the older instruction, so it always wins the refill of M.
      if (r_s_valid) begin
        r_m_data  <= r_s_data;
        r_m_valid <= 1'b1;
        r_s_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_m_data  <= i_in_data;
        r_m_valid <= 1'b1;
      end else begin
        r_m_valid <= 1'b0;
        r_m_data  <= i_idle_data;
      end
    end else if (w_in_fire) begin
      r_s_data  <= i_in_data;
      r_s_valid <= 1'b1;
    end
  end

  assign o_in_ready  = !r_s_valid;
  assign o_out_valid = r_m_valid;
  assign o_out_data  = r_m_data;

endmodule

// File: rtl/ladybird_inst_decoder.sv
// Registered RV32I decoder: decodes on the input side and parks the result in a
// skid buffer so the fetch-side ready stays a register output.
module ladybird_inst_decoder
  import ladybird_riscv_helper::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC_FIELD = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [XLEN-1:0] o_pc,
  output inst_class_t     o_class,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic [31:0]     o_imm,
  output logic            o_rd_we,
  output logic            o_illegal
);

  decoded_inst_t w_dec;
  decoded_inst_t w_idle;
  decoded_inst_t w_out;

  always_comb begin
    w_dec  = decode_inst(i_inst, i_pc);
    w_idle = '0;
    w_idle.pc         = RESET_PC_FIELD;
    w_idle.inst_class = CLS_ILLEGAL;
  end

  ladybird_skid_buffer #(
    .T (decoded_inst_t)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_flush),
    .i_idle_data (w_idle),
    .i_in_valid  (i_valid),
    .o_in_ready  (i_ready),
    .i_in_data   (w_dec),
    .o_out_valid (o_valid),
    .i_out_ready (o_ready),
    .o_out_data  (w_out)
  );

  assign o_pc      = w_out.pc;
  assign o_class   = w_out.inst_class;
  assign o_rd      = w_out.rd;
  assign o_rs1     = w_out.rs1;
  assign o_rs2     = w_out.rs2;
  assign o_funct3  = w_out.funct3;
  assign o_imm     = w_out.imm;
  assign o_rd_we   = w_out.rd_we;
  assign o_illegal = w_out.illegal;

endmodule

// File: tb/tb_ladybird_inst_decoder.sv
// Scoreboard bench for ladybird_inst_decoder: a reference decoder queues the
// expected result at each accept and outputs are popped and compared on drain.
module tb_ladybird_inst_decoder;
  import ladybird_riscv_helper::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] i_inst = '0;
  logic [31:0] i_pc = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_pc;
  inst_class_t o_class;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_funct3;
  logic [31:0] o_imm;
  logic        o_rd_we, o_illegal;

  int n_checks = 0;
  int n_pass   = 0;
  decoded_inst_t sb[$];
  logic [31:0] tbl[16];
  logic rnd_done;

  ladybird_inst_decoder #(.XLEN(32), .RESET_PC_FIELD(RST_PC)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .i_ready(i_ready),
    .i_inst(i_inst), .i_pc(i_pc), .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc),
    .o_class(o_class), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct3(o_funct3),
    .o_imm(o_imm), .o_rd_we(o_rd_we), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Reference decoder, organised by instruction format rather than opcode flow.
  function automatic decoded_inst_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    decoded_inst_t e;
    logic [31:0] ii, is, ib, iu, ij;
    logic ok, wr;
    ii = {{20{w[31]}}, w[31:20]};
    is = {{20{w[31]}}, w[31:25], w[11:7]};
    ib = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    iu = {w[31:12], 12'h000};
    ij = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    e = '0;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.funct3 = w[14:12];
    ok = 1'b1; wr = 1'b0;
    case (w[6:0])
      7'h03: begin e.inst_class = CLS_LOAD; e.imm = ii; wr = 1; ok = (w[14:12] inside {0,1,2,4,5}); end
      7'h23: begin e.inst_class = CLS_STORE; e.imm = is; ok = (w[14:12] inside {0,1,2}); end
      7'h13: begin
        e.inst_class = CLS_OP_IMM; wr = 1;
        if (w[14:12] == 1) begin e.imm = {27'd0, w[24:20]}; ok = (w[31:25] == 0); end
        else if (w[14:12] == 5) begin e.imm = {27'd0, w[24:20]}; ok = (w[31:25] inside {7'h00, 7'h20}); end
        else e.imm = ii;
      end
      7'h33: begin
        e.inst_class = CLS_OP; wr = 1;
        ok = (w[31:25] == 0) || (w[31:25] == 7'h20 && w[14:12] inside {0, 5});
      end
      7'h37: begin e.inst_class = CLS_LUI; e.imm = iu; wr = 1; end
      7'h17: begin e.inst_class = CLS_AUIPC; e.imm = iu; wr = 1; end
      7'h63: begin e.inst_class = CLS_BRANCH; e.imm = ib; ok = !(w[14:12] inside {2, 3}); end
      7'h6F: begin e.inst_class = CLS_JAL; e.imm = ij; wr = 1; end
      7'h67: begin e.inst_class = CLS_JALR; e.imm = ii; wr = 1; ok = (w[14:12] == 0); end
      7'h0F: e.inst_class = CLS_MISC_MEM;
      7'h73: begin
        e.inst_class = CLS_SYSTEM;
        if (w[14:12] == 0) ok = (w inside {32'h00000073, 32'h00100073, 32'h30200073});
        else if (w[14:12] == 4) ok = 0;
        else wr = 1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin e.inst_class = CLS_ILLEGAL; e.imm = '0; wr = 0; end
    e.rd_we = wr && (w[11:7] != 0);
    e.illegal = !ok;
    return e;
  endfunction

  // Monitor: sampled on the falling edge for the transfers of the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && o_ready && !i_flush) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(o_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          decoded_inst_t e;
          e = sb.pop_front();
          chk("out_pc", 64'(o_pc), 64'(e.pc));
          chk("out_class", 64'(o_class), 64'(e.inst_class));
          chk("out_fields", 64'({o_rd, o_rs1, o_rs2, o_funct3}), 64'({e.rd, e.rs1, e.rs2, e.funct3}));
          chk("out_imm", 64'(o_imm), 64'(e.imm));
          chk("out_flags", 64'({o_rd_we, o_illegal}), 64'({e.rd_we, e.illegal}));
          $display("out pc=%h class=%0d rd=%0d imm=%h we=%0d ill=%0d", o_pc, o_class, o_rd, o_imm, o_rd_we, o_illegal);
        end
      end
      if (i_flush) sb.delete();
      else if (i_valid && i_ready) sb.push_back(ref_decode(i_inst, i_pc));
    end
  end

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    logic ok;
    int guard;
    i_valid = 1'b1; i_inst = inst; i_pc = pc;
    guard = 0;
    do begin
      @(negedge clk); ok = i_ready;
      @(posedge clk); guard++;
    end while (!ok && guard < 50);
    if (!ok) chk("send_timeout", 64'(guard), 64'd0);
    #1;
  endtask

  task automatic drain();
    int guard;
    i_valid = 1'b0; o_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin @(posedge clk); guard++; end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{32'h00412083, 32'h00112223, 32'h123450B7, 32'h00001117, 32'h4030D093, 32'h02009093,
            32'h000080E7, 32'h0FF0000F, 32'h00000073, 32'h30200073, 32'h30529073, 32'h00004073,
            32'h002081B3, 32'h402081B3, 32'h0000B003, 32'h00209463};
    // Reset state
    #12;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    chk("rst_o_pc", 64'(o_pc), 64'(RST_PC));
    chk("rst_o_class", 64'(o_class), 64'(CLS_ILLEGAL));
    chk("rst_imm_flags", 64'({o_imm, o_rd_we, o_illegal, o_rd}), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ADDI x1,x2,-1
    o_ready = 1'b1;
    send(32'hFFF10093, 32'h0000_1000);
    chk("addi_valid", 64'(o_valid), 64'd1);
    chk("addi_class", 64'(o_class), 64'(CLS_OP_IMM));
    chk("addi_rd_rs1", 64'({o_rd, o_rs1}), 64'({5'd1, 5'd2}));
    chk("addi_imm", 64'(o_imm), 64'hFFFF_FFFF);
    chk("addi_flags", 64'({o_rd_we, o_illegal}), 64'b10);

    // JAL then BEQ back to back
    send(32'h001000EF, 32'h0000_1004);
    chk("jal_imm", 64'(o_imm), 64'h0000_0800);
    chk("jal_we", 64'(o_rd_we), 64'd1);
    send(32'hFE000EE3, 32'h0000_1008);
    i_valid = 1'b0;
    chk("beq_no_bubble", 64'(o_valid), 64'd1);
    chk("beq_imm", 64'(o_imm), 64'hFFFF_FFFC);
    chk("beq_we", 64'(o_rd_we), 64'd0);

    // Illegal encodings
    send(32'h00000000, 32'h0000_100C);
    i_valid = 1'b0;
    chk("zero_ill", 64'({o_illegal, o_rd_we}), 64'b10);
    chk("zero_class", 64'(o_class), 64'(CLS_ILLEGAL));
    send(32'h402090B3, 32'h0000_1010);
    i_valid = 1'b0;
    chk("sll_ill", 64'({o_illegal, o_rd_we}), 64'b10);
    chk("sll_class", 64'(o_class), 64'(CLS_ILLEGAL));
    drain();

    // Stall with skid: o_ready low for three edges
    o_ready = 1'b0;
    i_valid = 1'b1; i_inst = 32'h00108093; i_pc = 32'h0000_2000;
    @(posedge clk); #1;
    chk("stall_ready_a", 64'(i_ready), 64'd1);
    i_pc = 32'h0000_2004; i_inst = 32'h00210113;
    @(posedge clk); #1;
    chk("stall_ready_fall", 64'(i_ready), 64'd0);
    i_pc = 32'h0000_2008; i_inst = 32'h00318193;
    @(posedge clk); #1;
    chk("stall_ready_held", 64'(i_ready), 64'd0);
    chk("stall_pc_held", 64'(o_pc), 64'h2000);
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_ready_rise", 64'(i_ready), 64'd1);
    for (int k = 2; k < 6; k++) send(32'h00008093 | (32'(k) << 20), 32'h0000_2000 + 32'(4 * k));
    drain();

    // Randomised stream with random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [31:0] w;
          w = (k % 2 == 0) ? tbl[$urandom_range(0, 15)] : $urandom();
          send(w, 32'h0000_4000 + 32'(4 * k));
          if ($urandom_range(0, 2) == 0) begin i_valid = 1'b0; @(posedge clk); #1; end
        end
        i_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin @(posedge clk); #1; o_ready = 1'($urandom_range(0, 1)); end
      end
    join
    drain();

    // Flush with both entries full and a same-edge input
    o_ready = 1'b0;
    send(32'h00500293, 32'h0000_3000);
    send(32'h00600313, 32'h0000_3004);
    chk("flush_pre_ready", 64'(i_ready), 64'd0);
    i_valid = 1'b1; i_inst = 32'h00700393; i_pc = 32'h0000_3008; i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_o_valid", 64'(o_valid), 64'd0);
    chk("flush_i_ready", 64'(i_ready), 64'd1);
    chk("flush_o_pc", 64'(o_pc), 64'(RST_PC));
    o_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_stays_empty", 64'(o_valid), 64'd0);

    // Asynchronous reset in the middle of a stall
    o_ready = 1'b0;
    send(32'h00800413, 32'h0000_5000);
    send(32'h00900493, 32'h0000_5004);
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_o_valid", 64'(o_valid), 64'd0);
    chk("arst_i_ready", 64'(i_ready), 64'd1);
    chk("arst_o_pc", 64'(o_pc), 64'(RST_PC));
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    o_ready = 1'b1;
    send(32'h00730293, 32'h0000_6000);
    i_valid = 1'b0;
    chk("post_rst_valid", 64'(o_valid), 64'd1);
    chk("post_rst_fields", 64'({o_rd, o_rs1, o_imm}), 64'({5'd5, 5'd6, 32'd7}));
    chk("post_rst_pc", 64'(o_pc), 64'h6000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ladybird_inst_decoder.md
Name: ladybird_inst_decoder

Overview:
- Registered RV32I instruction decoder for the ladybird fetch-to-execute path; the inverse of the team's instruction-constructor helpers.
- Accepts a 32-bit instruction word and PC over a valid/ready handshake.
- Returns operand indices, funct3, an opcode class, a sign-extended immediate, a write-enable and an illegal flag, all registered.
- A one-entry skid buffer keeps `i_ready` a pure register output. Full throughput, 1-cycle latency.

Parameters:
- XLEN, 32, data/PC width; only 32 is supported.
- RESET_PC_FIELD, 0, reset value driven on `o_pc` while invalid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_flush  in  1  discard all buffered instructions
- i_valid  in  1  input instruction valid
- i_ready  out  1  decoder can accept; registered
- i_inst  in  32  instruction word
- i_pc  in  XLEN  instruction address
- o_valid  out  1  decoded output valid
- o_ready  in  1  consumer accepts
- o_pc  out  XLEN  PC of the decoded instruction
- o_class  out  4  opcode class, a package enum
- o_rd  out  5  destination register index
- o_rs1  out  5  source register 1 index
- o_rs2  out  5  source register 2 index
- o_funct3  out  3  funct3 field
- o_imm  out  32  sign-extended immediate
- o_rd_we  out  1  writes rd
- o_illegal  out  1  illegal instruction

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - `o_valid` = 0, `i_ready` = 1, skid buffer empty.
  - `o_pc` = RESET_PC_FIELD; all other outputs 0; `o_class` = CLS_ILLEGAL.
- Handshake:
  - A transfer occurs on a rising edge with valid && ready.
  - Output registers hold stable while `o_valid` && !`o_ready`.
- Latency: an instruction accepted at edge N appears with `o_valid` = 1 after edge N.
- Storage: main register M and skid register S.
  - `i_ready` (registered) = !S.valid.
  - Accept while M is empty or draining → decode into M.
  - Accept while M is stalled → decode into S.
  - When M drains and S is valid → S moves to M and `i_ready` returns to 1 on the same edge.
  - Never more than 2 instructions are held; order is preserved.
- Flush: `i_flush` = 1 at an edge clears M.valid and S.valid and drops any same-edge input transfer. `i_ready` = 1 afterwards. Flush has priority over all other events.
- Opcode classes: LOAD, STORE, OP_IMM, OP, LUI, AUIPC, BRANCH, JAL, JALR, MISC_MEM, SYSTEM, ILLEGAL.
- Immediates are sign-extended from inst[31]:
  - I-type: [31:20]
  - S-type: {[31:25],[11:7]}
  - B-type: {[31],[7],[30:25],[11:8],0}
  - U-type: {[31:12],12'b0}
  - J-type: {[31],[19:12],[20],[30:21],0}
  - Shift-immediates: zero-extended [24:20]
  - Other classes: 0
- Illegal (`o_illegal` = 1, `o_class` = ILLEGAL, `o_rd_we` = 0), when any of:
  - inst[1:0] != 2'b11, or unknown opcode
  - LOAD funct3 ∈ {3,6,7}
  - STORE funct3 > 2
  - BRANCH funct3 ∈ {2,3}
  - JALR funct3 != 0
  - SLLI funct7 != 0
  - SRLI/SRAI funct7 ∉ {0, 0x20}
  - OP funct7 ∉ {0, 0x20}, or funct7 = 0x20 with funct3 ∉ {0,5}
  - SYSTEM funct3 = 4
  - SYSTEM funct3 = 0 with inst ∉ {ECALL, EBREAK, MRET}
- `o_rd_we` = 1 for LOAD, OP_IMM, OP, LUI, AUIPC, JAL, JALR and SYSTEM-CSR (funct3 != 0), and only when rd != 0.
- `o_rs1`, `o_rs2` and `o_funct3` are raw field copies regardless of class.

Decomposition:
- In ladybird_riscv_helper:
  - opcode-class enum `inst_class_t`
  - packed struct `decoded_inst_t` with fields pc, class, rd, rs1, rs2, funct3, imm, rd_we, illegal
  - pure function `decode_inst(inst, pc)` returning `decoded_inst_t`, reusing the existing OPCODE_* constants
- Sub-module ladybird_skid_buffer #(type T), containing the M/S registers and handshake. The decoder instantiates it with `decoded_inst_t` and calls `decode_inst` on its input side.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), `o_ready` = 1 → next cycle:
  - class OP_IMM, rd 1, rs1 2, imm 0xFFFFFFFF, rd_we 1, illegal 0.
- JAL x1,+0x800 (0x001000EF), then BEQ x0,x0,-4 (0xFE000EE3) back-to-back → consecutive outputs:
  - JAL with imm 0x00000800, rd_we 1
  - BEQ with imm 0xFFFFFFFC, rd_we 0
  - no bubble between them
- Stream of 6 ADDIs with distinct PCs, `o_ready` held 0 for 3 cycles:
  - `i_ready` falls exactly one edge after the second accept while stalled.
  - No loss or duplication; PCs emerge in order.
  - `i_ready` rises on the first drain edge.
- 0x00000000 and SUB-form SLL (0x402090B3) → both `o_illegal` = 1, class ILLEGAL, rd_we 0.
- Both M and S full, `i_flush` pulsed together with `i_valid` →
  - `o_valid` = 0 and `i_ready` = 1 next cycle.
  - Flushed and same-edge instructions never appear.
- `rst` asserted mid-stall, asynchronously between edges → `o_valid` drops immediately, before the next edge. After release, the first new input decodes correctly.
